// File: rtl/bit_tx_pkg.sv
// bit_tx_pkg
//   Shared definitions for the pulse-distance bit transmitter:
//   - state_e     : controller FSM state encoding
//   - DEF_*       : default timing constants (clock cycles)
//   - max_int()   : helper used to size the cycle timer
package bit_tx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START_MARK,
    START_SPACE,
    BIT_MARK,
    BIT_SPACE,
    ADVANCE,
    CHECK,
    STOP_MARK,
    DONE
  } state_e;

  localparam int DEF_START_MARK_CYC  = 16;
  localparam int DEF_START_SPACE_CYC = 8;
  localparam int DEF_MARK_CYC        = 4;
  localparam int DEF_ZERO_SPACE_CYC  = 4;
  localparam int DEF_ONE_SPACE_CYC   = 12;
  localparam int DEF_MAX_BITS        = 11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_tx_ctrl_cycle_timer.sv
// cycle_timer
//   Loadable down-counter used to time each FSM state.
//   Ports:
//     clk      in  clock, rising edge
//     rst      in  asynchronous active-high reset (count -> 0)
//     load     in  load load_val this cycle
//     load_val in  W   count value (state length minus one)
//     expired  out count has reached zero
module cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/bit_tx_ctrl.sv
// bit_tx_ctrl
//   Pulse-distance encoder controller. Emits a start burst/gap, then per bit a
//   fixed mark followed by a space whose length encodes the bit, then a stop
//   mark and a one-cycle done pulse. Bits come from an external serializer.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset
//     start     in   frame request (sampled in IDLE only)
//     abort     in   synchronous cancel, highest priority
//     bits_done in   serializer has no bits left
//     bit_value in   serializer's current bit
//     next_bit  out  one-cycle advance strobe to serializer
//     tx_out    out  encoded line
//     busy      out  high whenever not IDLE
//     done      out  one-cycle frame-complete pulse
//     err       out  one-cycle pulse when MAX_BITS is exceeded
//     bit_cnt   out  [3:0] bits sent in current frame
module bit_tx_ctrl
  import bit_tx_pkg::*;
#(
  parameter int START_MARK_CYC  = DEF_START_MARK_CYC,
  parameter int START_SPACE_CYC = DEF_START_SPACE_CYC,
  parameter int MARK_CYC        = DEF_MARK_CYC,
  parameter int ZERO_SPACE_CYC  = DEF_ZERO_SPACE_CYC,
  parameter int ONE_SPACE_CYC   = DEF_ONE_SPACE_CYC,
  parameter int MAX_BITS        = DEF_MAX_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       bits_done,
  input  logic       bit_value,
  output logic       next_bit,
  output logic       tx_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] bit_cnt
);

  localparam int MAX_CYC = max_int(max_int(max_int(START_MARK_CYC, START_SPACE_CYC),
                                           max_int(MARK_CYC, ZERO_SPACE_CYC)),
                                   ONE_SPACE_CYC);
  localparam int CW = $clog2(MAX_CYC) + 1;

  // The timer holds "remaining cycles minus one", so a state loaded with N-1
  // stays for exactly N cycles before expired is seen.
  localparam logic [CW-1:0] LD_START_MARK  = CW'(START_MARK_CYC - 1);
  localparam logic [CW-1:0] LD_START_SPACE = CW'(START_SPACE_CYC - 1);
  localparam logic [CW-1:0] LD_MARK        = CW'(MARK_CYC - 1);
  localparam logic [CW-1:0] LD_ZERO_SPACE  = CW'(ZERO_SPACE_CYC - 1);
  localparam logic [CW-1:0] LD_ONE_SPACE   = CW'(ONE_SPACE_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        bit_lat_q, bit_lat_d;
  logic        tx_out_q, tx_out_d;
  logic        busy_q, busy_d;
  logic        next_bit_q, next_bit_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        timer_load;
  logic [CW-1:0] timer_val;
  logic        timer_expired;

  cycle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_lat_d  = bit_lat_q;
    timer_load = 1'b0;
    timer_val  = '0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = START_MARK;
          bit_cnt_d  = 4'd0;
          timer_load = 1'b1;
          timer_val  = LD_START_MARK;
        end
      end
      START_MARK: begin
        if (timer_expired) begin
          state_d    = START_SPACE;
          timer_load = 1'b1;
          timer_val  = LD_START_SPACE;
        end
      end
      START_SPACE: begin
        if (timer_expired) state_d = CHECK;
      end
      CHECK: begin
        timer_load = 1'b1;
        timer_val  = LD_MARK;
        if (bits_done) begin
          state_d = STOP_MARK;
        end else if (bit_cnt_q == 4'(MAX_BITS)) begin
          state_d = STOP_MARK;
          err_d   = 1'b1;
        end else begin
          state_d   = BIT_MARK;
          // The bit is captured once here; later serializer changes cannot
          // alter this bit's space length.
          bit_lat_d = bit_value;
        end
      end
      BIT_MARK: begin
        if (timer_expired) begin
          state_d    = BIT_SPACE;
          timer_load = 1'b1;
          timer_val  = bit_lat_q ? LD_ONE_SPACE : LD_ZERO_SPACE;
        end
      end
      BIT_SPACE: begin
        if (timer_expired) begin
          state_d   = ADVANCE;
          bit_cnt_d = (bit_cnt_q == 4'hF) ? bit_cnt_q : bit_cnt_q + 4'd1;
        end
      end
      ADVANCE:   state_d = CHECK;
      STOP_MARK: begin
        if (timer_expired) state_d = DONE;
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      err_d      = 1'b0;
      timer_load = 1'b1;
      timer_val  = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up
  // cycle-for-cycle with the state register and are glitch-free.
  always_comb begin
    tx_out_d   = (state_d == START_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);
    busy_d     = (state_d != IDLE);
    next_bit_d = (state_d == ADVANCE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      bit_lat_q  <= 1'b0;
      tx_out_q   <= 1'b0;
      busy_q     <= 1'b0;
      next_bit_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_lat_q  <= bit_lat_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= busy_d;
      next_bit_q <= next_bit_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign busy     = busy_q;
  assign next_bit = next_bit_q;
  assign done     = done_q;
  assign err      = err_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_bit_tx_ctrl.sv
module tb_bit_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       bits_done, bit_value;
  logic       next_bit, tx_out, busy, done, err;
  logic [3:0] bit_cnt;

  // serializer stub
  logic [15:0] stub_bits;
  logic [4:0]  stub_len;
  logic [4:0]  stub_idx;
  logic        stub_clr;

  int errors = 0;
  int checks = 0;

  // frame capture results
  int         runs[32];
  int         nruns;
  int         nb_cnt, err_cnt;
  bit         consec_nb, found;
  logic [3:0] cnt_at_done;
  logic       tx_at_done;
  int         exp_runs[32];
  int         exp_n;

  always #5 clk = ~clk;

  bit_tx_ctrl #(
    .START_MARK_CYC (16),
    .START_SPACE_CYC(8),
    .MARK_CYC       (4),
    .ZERO_SPACE_CYC (4),
    .ONE_SPACE_CYC  (12),
    .MAX_BITS       (11)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .bits_done(bits_done),
    .bit_value(bit_value),
    .next_bit (next_bit),
    .tx_out   (tx_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bit_cnt  (bit_cnt)
  );

  always @(posedge clk) begin
    if (stub_clr)      stub_idx <= 5'd0;
    else if (next_bit) stub_idx <= stub_idx + 5'd1;
  end
  assign bit_value = stub_bits[stub_idx[3:0]];
  assign bits_done = (stub_idx >= stub_len);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected tx_out run lengths: start mark, start gap + CHECK, then per bit
  // a mark and (space + ADVANCE + CHECK), then stop mark and the DONE cycle.
  task automatic build_exp(input logic [15:0] bits, input int nbits);
    exp_n = 0;
    exp_runs[exp_n++] = 16;
    exp_runs[exp_n++] = 8 + 1;
    for (int k = 0; k < nbits; k++) begin
      exp_runs[exp_n++] = 4;
      exp_runs[exp_n++] = (bits[k] ? 12 : 4) + 2;
    end
    exp_runs[exp_n++] = 4;
    exp_runs[exp_n++] = 1;
  endtask

  task automatic stub_clear();
    @(negedge clk); stub_clr = 1'b1;
    @(negedge clk); stub_clr = 1'b0;
  endtask

  // Starts a frame and records tx_out run lengths until done (bounded).
  task automatic run_frame(input int poke_idx, input bit hold);
    int cur_len;
    logic cur_val;
    bit prev_nb;
    stub_clear();
    start = 1'b1;
    for (int k = 0; k < 32; k++) runs[k] = 0;
    nruns = 0; nb_cnt = 0; err_cnt = 0; consec_nb = 0; found = 0;
    prev_nb = 0; cur_len = 0; cur_val = 1'b0;
    cnt_at_done = 4'd0; tx_at_done = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = hold ? 1'b1 : (i == poke_idx);
      if (i == 0) begin
        cur_val = tx_out; cur_len = 1;
      end else if (tx_out === cur_val) begin
        cur_len++;
      end else begin
        if (nruns < 32) runs[nruns++] = cur_len;
        cur_val = tx_out; cur_len = 1;
      end
      if (next_bit === 1'b1) begin
        if (prev_nb) consec_nb = 1;
        nb_cnt++;
      end
      prev_nb = (next_bit === 1'b1);
      if (err === 1'b1) err_cnt++;
      if (done === 1'b1) begin
        if (nruns < 32) runs[nruns++] = cur_len;
        cnt_at_done = bit_cnt;
        tx_at_done  = tx_out;
        found = 1;
        break;
      end
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int nb_exp, input int err_exp,
                             input int cnt_exp);
    chk({tag, ".found"}, 32'(found), 1);
    chk({tag, ".nruns"}, nruns, exp_n);
    for (int k = 0; k < exp_n; k++)
      chk($sformatf("%s.run%0d", tag, k), runs[k], exp_runs[k]);
    chk({tag, ".next_bit_pulses"}, nb_cnt, nb_exp);
    chk({tag, ".next_bit_consec"}, 32'(consec_nb), 0);
    chk({tag, ".err_pulses"}, err_cnt, err_exp);
    chk({tag, ".bit_cnt"}, 32'(cnt_at_done), cnt_exp);
    chk({tag, ".tx_at_done"}, 32'(tx_at_done), 0);
    $display("frame %s: runs=%0d next_bit=%0d err=%0d bit_cnt=%0d", tag, nruns, nb_cnt,
             err_cnt, cnt_at_done);
  endtask

  task automatic check_after_done(input string tag);
    @(negedge clk);
    chk({tag, ".done_one_cycle"}, 32'(done), 0);
    chk({tag, ".idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    bit stray;
    rst = 1'b1; start = 1'b0; abort = 1'b0; stub_clr = 1'b1;
    stub_bits = 16'h0000; stub_len = 5'd0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.tx_out", 32'(tx_out), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.next_bit", 32'(next_bit), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.bit_cnt", 32'(bit_cnt), 0);
    rst = 1'b0; stub_clr = 1'b0;
    @(negedge clk);

    // bits 1,0 then bits_done
    stub_bits = 16'b01; stub_len = 5'd2;
    run_frame(-1, 1'b0);
    build_exp(16'b01, 2);
    check_frame("bits10", 2, 0, 2);
    check_after_done("bits10");

    // bits_done before start: empty frame
    stub_bits = 16'h0000; stub_len = 5'd0;
    run_frame(-1, 1'b0);
    build_exp(16'h0000, 0);
    check_frame("empty", 0, 0, 0);
    check_after_done("empty");

    // bits 1,1,0
    stub_bits = 16'b011; stub_len = 5'd3;
    run_frame(-1, 1'b0);
    build_exp(16'b011, 3);
    check_frame("bits110", 3, 0, 3);
    check_after_done("bits110");

    // bits_done never asserted: MAX_BITS overrun
    stub_bits = 16'h0555; stub_len = 5'd31;
    run_frame(-1, 1'b0);
    build_exp(16'h0555, 11);
    check_frame("overrun", 11, 1, 11);
    check_after_done("overrun");

    // start pulsed while busy is ignored
    stub_bits = 16'b01; stub_len = 5'd2;
    run_frame(30, 1'b0);
    build_exp(16'b01, 2);
    check_frame("start_busy", 2, 0, 2);
    check_after_done("start_busy");

    // start held through the frame: ignored while busy, restarts on first IDLE
    run_frame(-1, 1'b1);
    check_frame("start_held", 2, 0, 2);
    @(negedge clk);
    chk("held.first_idle_busy", 32'(busy), 0);
    @(negedge clk);
    chk("held.restart_busy", 32'(busy), 1);
    chk("held.restart_tx", 32'(tx_out), 1);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("held.abort_busy", 32'(busy), 0);

    // abort during the second BIT_SPACE (sample index 48)
    stub_clear();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (48) @(negedge clk);
    chk("abort.pre_busy", 32'(busy), 1);
    chk("abort.pre_tx", 32'(tx_out), 0);
    chk("abort.pre_bit_cnt", 32'(bit_cnt), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.tx_out", 32'(tx_out), 0);
    stray = 0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) stray = 1;
    end
    chk("abort.no_done", 32'(stray), 0);
    $display("frame abort: busy=%0d tx_out=%0d", busy, tx_out);

    // asynchronous reset in the middle of the first BIT_MARK (sample index 26)
    stub_bits = 16'b01; stub_len = 5'd2;
    stub_clear();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (26) @(negedge clk);
    chk("arst.pre_tx", 32'(tx_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst.tx_out", 32'(tx_out), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.bit_cnt", 32'(bit_cnt), 0);
    @(negedge clk); rst = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (next_bit !== 1'b0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) stray = 1;
    end
    chk("arst.no_strobe", 32'(stray), 0);
    run_frame(-1, 1'b0);
    build_exp(16'b01, 2);
    check_frame("after_rst", 2, 0, 2);
    check_after_done("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
